// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with wait states, load extension and store byte merging
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  data_format,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        access_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    fmt_q, fmt_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          idle;
  logic          cur_rd, cur_wr, cur_fault;
  logic [AW+1:0] cur_addr;
  logic [2:0]    cur_fmt;
  logic [31:0]   cur_word;
  logic          commit;
  logic [3:0]    be;
  logic [31:0]   wd_lanes;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^address[31:AW+2];

  // With zero wait states the response is formed from the live inputs in IDLE,
  // so every decode works on the "current" request rather than the latched copy.
  assign idle     = (state_q == S_IDLE);
  assign cur_rd   = idle ? read_enable : rd_q;
  assign cur_wr   = idle ? write_enable : wr_q;
  assign cur_addr = idle ? address[AW+1:0] : addr_q;
  assign cur_fmt  = idle ? data_format : fmt_q;
  assign cur_word = mem_q[cur_addr[AW+1:2]];

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] fmt,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (fmt)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      3'b010:  return word;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    cur_fault = cur_rd && cur_wr;
    case (cur_fmt)
      3'b001, 3'b101:         if (cur_addr[0]) cur_fault = 1'b1;
      3'b010:                 if (cur_addr[1:0] != 2'b00) cur_fault = 1'b1;
      3'b011, 3'b110, 3'b111: cur_fault = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fmt_d   = fmt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (read_enable || write_enable) begin
          addr_d  = address[AW+1:0];
          wdata_d = write_data;
          fmt_d   = data_format;
          rd_d    = read_enable;
          wr_d    = write_enable;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESP && state_q != S_RESP)
      rdata_d = (cur_fault || cur_wr) ? 32'd0 : extend_load(cur_word, cur_fmt, cur_addr[1:0]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      fmt_q   <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fmt_q   <= fmt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Store data is replicated across lanes; the byte enables pick the lanes that change.
  always_comb begin
    be       = 4'b0000;
    wd_lanes = wdata_q;
    case (fmt_q)
      3'b010: be = 4'b1111;
      3'b001: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{wdata_q[15:0]}};
      end
      3'b000: begin
        be       = 4'b0001 << addr_q[1:0];
        wd_lanes = {4{wdata_q[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  assign commit = (state_q == S_RESP) && cur_wr && !cur_fault;

  always_ff @(posedge clock) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr_q[AW+1:2]][8*b +: 8] <= wd_lanes[8*b +: 8];
      end
    end
  end

  assign ready        = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign access_fault = ready && cur_fault;
  assign read_data    = rdata_q;

endmodule
